uart_rx_ctrl: RTL and testbench

//   Receive-side UART frame controller. Sequences a shared oversampling baud

---
 rtl/uart_rx_ctrl.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// Receive-side UART frame controller.
// Drives a shared oversampling baud generator, detects the start bit, samples
// each bit at its centre and presents completed frames on a valid/ready register.
module uart_rx_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 CLKIN,
  input  logic                 RESET,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_restart,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 restart_q, restart_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 tick_en;

  // A tick arriving together with the restart strobe belongs to the old phase.
  assign tick_en = baud_tick && !restart_q;

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Frame sequencing, bit assembly and output handshake next-state logic.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    restart_d  = 1'b0;
    ferr_d     = 1'b0;
    ovr_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          restart_d  = 1'b1;
          tick_cnt_d = '0;
          state_d    = S_START;
        end
      end

      S_START: begin
        if (tick_en) begin
          if (tick_cnt_q == HALF_LAST) begin
            if (rx_s_q) begin
              state_d = S_IDLE;
            end else begin
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
              state_d    = S_DATA;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick_en) begin
          if (tick_cnt_q == FULL_LAST) begin
            shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
            tick_cnt_d = '0;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BITS_LAST) begin
              state_d = S_STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (tick_en) begin
          if (tick_cnt_q == FULL_LAST) begin
            tick_cnt_d = '0;
            if (rx_s_q) begin
              // A consumer taking the old byte this cycle frees the slot.
              if (!rx_valid_q || rx_ready) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_BREAK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      restart_q  <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      restart_q  <= restart_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign baud_restart = restart_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_err    = ferr_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: 16x oversampling, baud tick every 4 clocks.
module tb_uart_rx_ctrl;

  logic       CLKIN = 1'b0;
  logic       RESET = 1'b1;
  logic       rx = 1'b1;
  logic       baud_tick;
  logic       baud_restart;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Event monitor state (updated on the falling edge).
  int cyc = 0;
  int restart_cnt = 0;
  int restart_cyc = 0;
  int rise_cyc = 0;
  int xfer_cnt = 0;
  int xfer_data = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int ovr_cyc = 0;
  bit prev_valid = 1'b0;

  // Baud generator model: tick every 4 clocks, phase cleared by baud_restart.
  logic [1:0] div_q = 2'd0;
  assign baud_tick = (div_q == 2'd3);

  always #5 CLKIN = ~CLKIN;

  always @(posedge CLKIN) begin
    if (baud_restart) div_q <= 2'd0;
    else              div_q <= div_q + 2'd1;
  end

  uart_rx_ctrl #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .CLKIN       (CLKIN),
    .RESET       (RESET),
    .rx          (rx),
    .baud_tick   (baud_tick),
    .baud_restart(baud_restart),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always @(negedge CLKIN) begin
    cyc <= cyc + 1;
    if (baud_restart) begin
      restart_cnt <= restart_cnt + 1;
      restart_cyc <= cyc;
    end
    if (rx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= rx_valid;
    if (rx_valid && rx_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      xfer_data <= int'(rx_data);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (overrun) begin
      ovr_cnt <= ovr_cnt + 1;
      ovr_cyc <= cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge CLKIN);
      #1;
    end
  endtask

  // One bit = 16 ticks * 4 clocks = 64 clocks; leaves the line at the stop value.
  task automatic send_frame(input logic [7:0] d, input logic stopv);
    rx = 1'b0;
    wait_cycles(64);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(64);
    end
    rx = stopv;
    wait_cycles(64);
  endtask

  task automatic wait_restart(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (baud_restart) begin
        ok = 1'b1;
        break;
      end
      wait_cycles(1);
    end
  endtask

  int b_r, b_x, b_f, b_o;
  bit seen;

  initial begin
    wait_cycles(4);
    RESET = 1'b0;
    wait_cycles(1);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_data", rx_data, 0);
    check("reset_baud_restart", baud_restart, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun", overrun, 0);
    wait_cycles(20);

    // Plain frame 0xA5: restart visible 609 cycles before rx_valid
    // (half-bit start check + 9 bits at 64 clocks + 1 tick phase + 1 latency).
    b_r = restart_cnt; b_x = xfer_cnt; b_f = ferr_cnt; b_o = ovr_cnt;
    send_frame(8'hA5, 1'b1);
    wait_cycles(20);
    check("a5_restarts", restart_cnt - b_r, 1);
    check("a5_xfers", xfer_cnt - b_x, 1);
    check("a5_data", xfer_data, 32'hA5);
    check("a5_latency", rise_cyc - restart_cyc, 609);
    check("a5_frame_err", ferr_cnt - b_f, 0);
    check("a5_overrun", ovr_cnt - b_o, 0);
    check("a5_valid_cleared", rx_valid, 0);
    check("a5_data_held", rx_data, 32'hA5);

    // Glitch: 5 ticks low is shorter than the half-bit start check.
    b_r = restart_cnt; b_x = xfer_cnt; b_f = ferr_cnt;
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(100);
    check("glitch_restarts", restart_cnt - b_r, 1);
    check("glitch_xfers", xfer_cnt - b_x, 0);
    check("glitch_frame_err", ferr_cnt - b_f, 0);
    send_frame(8'h3C, 1'b1);
    wait_cycles(20);
    check("3c_xfers", xfer_cnt - b_x, 1);
    check("3c_data", xfer_data, 32'h3C);

    // Stop bit low, line held low 3 more bit times.
    b_r = restart_cnt; b_x = xfer_cnt; b_f = ferr_cnt;
    send_frame(8'h55, 1'b0);
    wait_cycles(192);
    check("brk_frame_err", ferr_cnt - b_f, 1);
    check("brk_xfers", xfer_cnt - b_x, 0);
    check("brk_rx_valid", rx_valid, 0);
    check("brk_no_restart", restart_cnt - b_r, 1);
    rx = 1'b1;
    wait_cycles(20);
    check("brk_idle_no_restart", restart_cnt - b_r, 1);
    send_frame(8'h0F, 1'b1);
    wait_cycles(20);
    check("0f_xfers", xfer_cnt - b_x, 1);
    check("0f_data", xfer_data, 32'h0F);

    // Overrun: consumer stalled across two frames.
    rx_ready = 1'b0;
    b_x = xfer_cnt; b_o = ovr_cnt;
    send_frame(8'h11, 1'b1);
    wait_cycles(20);
    check("ovr_first_valid", rx_valid, 1);
    send_frame(8'h22, 1'b1);
    wait_cycles(20);
    check("ovr_pulses", ovr_cnt - b_o, 1);
    check("ovr_at_stop_sample", ovr_cyc - restart_cyc, 609);
    check("ovr_data_held", rx_data, 32'h11);
    check("ovr_valid_held", rx_valid, 1);
    rx_ready = 1'b1;
    wait_cycles(1);
    check("ovr_consumed_xfers", xfer_cnt - b_x, 1);
    check("ovr_consumed_data", xfer_data, 32'h11);
    check("ovr_valid_cleared", rx_valid, 0);
    wait_cycles(20);

    // Consumer accepts exactly in the stop-sample cycle of the second frame.
    rx_ready = 1'b0;
    b_x = xfer_cnt; b_o = ovr_cnt;
    send_frame(8'h11, 1'b1);
    wait_cycles(20);
    fork
      send_frame(8'h22, 1'b1);
      begin
        wait_restart(seen);
        check("same_cycle_restart_seen", seen, 1);
        wait_cycles(608);
        rx_ready = 1'b1;
        wait_cycles(1);
        rx_ready = 1'b0;
        check("same_cycle_valid", rx_valid, 1);
        check("same_cycle_data", rx_data, 32'h22);
        check("same_cycle_old_taken", xfer_data, 32'h11);
      end
    join
    wait_cycles(20);
    check("same_cycle_no_overrun", ovr_cnt - b_o, 0);
    rx_ready = 1'b1;
    wait_cycles(2);
    check("same_cycle_drained_valid", rx_valid, 0);
    check("same_cycle_drained_data", xfer_data, 32'h22);
    wait_cycles(20);

    // Reset in the middle of the data bits of 0xFF.
    b_r = restart_cnt; b_x = xfer_cnt; b_f = ferr_cnt;
    fork
      send_frame(8'hFF, 1'b1);
      begin
        wait_cycles(200);
        RESET = 1'b1;
        wait_cycles(1);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_rx_data", rx_data, 0);
        check("rst_mid_restart", baud_restart, 0);
        check("rst_mid_frame_err", frame_err, 0);
        check("rst_mid_overrun", overrun, 0);
        RESET = 1'b0;
      end
    join
    wait_cycles(20);
    check("rst_mid_no_byte", xfer_cnt - b_x, 0);
    check("rst_mid_no_ferr", ferr_cnt - b_f, 0);
    check("rst_mid_restarts", restart_cnt - b_r, 1);
    send_frame(8'h81, 1'b1);
    wait_cycles(20);
    check("81_xfers", xfer_cnt - b_x, 1);
    check("81_data", xfer_data, 32'h81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
